// File: rtl/ones_fill_gen.sv
// Serial ones-fill generator: builds an r1_size-bit word holding min(count, r1_size)
// right-justified ones by shifting a 1 into a cleared register once per cycle.
module ones_fill_gen #(
    parameter int r1_size = 8,
    parameter int r2_size = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [r2_size-1:0] count,
    output logic [r1_size-1:0] data,
    output logic               rdy,
    output logic               done,
    output logic               sat
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [r2_size-1:0] CNT_ONE = r2_size'(1);

    state_t             state_reg, state_next;
    logic [r1_size-1:0] r1_reg, r1_next;
    logic [r2_size-1:0] cnt_reg, cnt_next;
    logic               sat_reg, sat_next;

    logic [r1_size-1:0] r1_shifted;
    logic               full;
    logic               zero;

    // Shift path: each bit takes its lower neighbour, a 1 enters at bit 0.
    generate
        for (genvar gi = 0; gi < r1_size; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign r1_shifted[gi] = 1'b1;
            end else begin : g_upper
                assign r1_shifted[gi] = r1_reg[gi-1];
            end
        end
    endgenerate

    assign full = &r1_reg;
    assign zero = (cnt_reg == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            r1_reg    <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            r1_reg    <= r1_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        r1_next    = r1_reg;
        cnt_next   = cnt_reg;
        sat_next   = sat_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    r1_next    = '0;
                    cnt_next   = count;
                    sat_next   = 1'b0;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (!zero && !full) begin
                    r1_next  = r1_shifted;
                    cnt_next = cnt_reg - CNT_ONE;
                end else begin
                    // Ones still owed but no room left means the request overflowed.
                    sat_next   = !zero && full;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign data = r1_reg;
    assign sat  = sat_reg;
    assign rdy  = (state_reg == IDLE);
    assign done = (state_reg == DONE);

endmodule

// File: doc/ones_fill_gen.md
# ones_fill_gen

Serial ones-fill generator: the inverse of the team's ones-counter datapath. Given a count `k`, it builds a `r1_size`-bit word containing exactly `k` ones, right-justified, by shifting a 1 into a cleared register once per cycle. Like the ones counter, it is split into a controller and a data path (shift register, down-counter, full detect). It sits downstream of that counter in round-trip checks and mask-generation paths.

## Interface
- `r1_size`, 8: width of the generated word (shift register).
- `r2_size`, 4: width of the requested count (down-counter). `2**r2_size - 1 > r1_size` is legal, and saturation handles it.

- `clk`  in  1  rising-edge clock; only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request. Sampled only while `rdy`=1.
- `count`  in  r2_size  number of ones requested. Captured on the accepted `start` edge.
- `data`  out  r1_size  generated word, direct register output. Valid while `done`=1, then held until the next accepted `start`.
- `rdy`  out  1  high in IDLE only.
- `done`  out  1  one-cycle pulse when `data` is final.
- `sat`  out  1  request exceeded `r1_size`. Registered; valid with `done` and held with `data`.

## Operation
- Controller states (2-bit encoded):
  - IDLE: `rdy`=1.
  - FILL: shifting.
  - DONE: `done`=1.
- IDLE:
  - On an edge with `start`=1: r1 <= 0, cnt <= `count`, `sat` <= 0, go to FILL.
  - Otherwise hold all registers.
- FILL, per edge, with `full` = (r1 == all ones) and `zero` = (cnt == 0):
  - If `zero`=0 and `full`=0: r1 <= {r1[r1_size-2:0], 1'b1}, cnt <= cnt - 1, stay in FILL.
  - Else: go to DONE and `sat` <= (`zero`=0 & `full`=1). r1 and cnt hold.
- DONE: unconditionally go to IDLE on the next edge.
- `start` is ignored in FILL and DONE. There is no queueing.
- Result `data` = `min(k, r1_size)` ones in bits [m-1:0] and zeros above, where m = `min(k, r1_size)`.
- The counter only decrements when `zero`=0, so it never wraps below 0.
- Both `zero`=1 and `full`=1 on the same cycle (k == r1_size): `sat`=0.
- `rst`=1 on an edge overrides everything, including mid-FILL.

## Timing
- Reset values, present after the first edge with `rst`=1:
  - state IDLE, r1=0, cnt=0.
  - `rdy`=1, `done`=0, `data`=0, `sat`=0.
- `rdy` and `done` are decoded from the state register only. No input-to-output combinational path exists.
- Latency for request `k`, where E0 = the accepting edge:
  - `rdy` drops in the cycle after E0.
  - Shifts occur on edges E1..Em, with m = `min(k, r1_size)`.
  - Edge Em+1 enters DONE, so `done` is high during the cycle after Em+1.
  - Edge Em+2 returns to IDLE, and `rdy`=1 in the cycle after Em+2.
- Throughput: `start` held continuously yields one result every m+3 cycles.
- Reset asserted mid-FILL: the next cycle shows IDLE/reset values. No `done` pulse occurs for the aborted request.

## Test plan
- Reset with `start`=1 and `count`=5 asserted -> during reset and the first cycle after: `rdy`=1, `done`=0, `data`=8'h00, `sat`=0. The request is not accepted until `rst`=0.
- `count`=3, one-cycle `start` -> `done` pulses exactly 5 cycles after the accepting edge with `data`=8'h07 and `sat`=0. `data` then holds 8'h07 while `rdy`=1.
- `count`=0 -> `done` 2 cycles after accept, `data`=8'h00, `sat`=0. Then `count`=8 -> `data`=8'hFF, `sat`=0, `done` 10 cycles after accept.
- `count`=4'hF (saturation) -> `data`=8'hFF, `sat`=1, `done` 10 cycles after accept. A following request with `count`=2 clears `sat` (8'h03, `sat`=0).
- `start` toggled during FILL and DONE with `count` changing -> the result reflects only the count captured at accept. Exactly one `done` pulse occurs per accepted request.
- `count`=6, `rst` pulsed for one cycle after 3 shifts -> no `done` pulse, `data`=8'h00, `rdy`=1. A new `count`=1 then gives 8'h01.
